// File: rtl/adc_avalon_slave.sv
// adc_avalon_slave: Avalon-MM slave publishing per-channel (optionally averaged) ADC results.
// Define ADC_OVERRUN_DETECT_EN to add sticky overrun flags in STATUS[31:16].
module adc_avalon_slave #(
    parameter int N_CH     = 8,
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 0
) (
    input  logic              sys_clk,
    input  logic              sys_reset,
    input  logic              sample_valid,
    input  logic [3:0]        sample_chan,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              chipselect,
    input  logic [4:0]        addr,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata
);

    localparam int         ACC_W    = DATA_W + AVG_LOG2;
    localparam logic [4:0] A_STATUS = 5'd16;
    localparam logic [4:0] A_CTRL   = 5'd17;
    localparam logic [4:0] A_CNT    = 5'd18;

    logic [DATA_W-1:0] live [N_CH];
    logic [DATA_W-1:0] shad [N_CH];
    logic [N_CH-1:0]   new_flag;
    logic [N_CH-1:0]   ovr_flag;
    logic [N_CH-1:0]   hit;
    logic [N_CH-1:0]   pub;
    logic              freeze;
    logic [31:0]       sample_cnt;
    logic [31:0]       status;
    logic [31:0]       rd_mux;
    logic              rd_stb;
    logic              rd_status;
    logic              ctrl_wr;
    logic              snap;
    logic              accept;
    logic              unused_wd;

    assign rd_stb    = chipselect && read;
    assign rd_status = rd_stb && (addr == A_STATUS);
    assign ctrl_wr   = chipselect && write && (addr == A_CTRL);
    assign snap      = ctrl_wr && writedata[0];
    assign accept    = |hit;
    assign unused_wd = ^writedata[31:1];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [DATA_W-1:0] res;
        logic [DATA_W-1:0] shd;
        logic              nf;

        assign hit[i] = sample_valid && (sample_chan == 4'(i));

        if (AVG_LOG2 == 0) begin : g_pass
            assign pub[i] = hit[i];

            always_ff @(posedge sys_clk or posedge sys_reset) begin
                if (sys_reset) begin
                    res <= '0;
                end else if (pub[i]) begin
                    res <= sample_data;
                end
            end
        end else begin : g_avg
            logic [ACC_W-1:0]    acc;
            logic [ACC_W-1:0]    sum;
            logic [AVG_LOG2-1:0] cnt;

            assign sum    = acc + ACC_W'(sample_data);
            assign pub[i] = hit[i] && (&cnt);

            always_ff @(posedge sys_clk or posedge sys_reset) begin
                if (sys_reset) begin
                    res <= '0;
                    acc <= '0;
                    cnt <= '0;
                end else if (hit[i]) begin
                    if (&cnt) begin
                        res <= DATA_W'(sum >> AVG_LOG2);
                        acc <= '0;
                        cnt <= '0;
                    end else begin
                        acc <= sum;
                        cnt <= cnt + AVG_LOG2'(1);
                    end
                end
            end
        end

        // Snapshot samples res before any same-edge publish lands.
        always_ff @(posedge sys_clk or posedge sys_reset) begin
            if (sys_reset) begin
                shd <= '0;
            end else if (snap) begin
                shd <= res;
            end
        end

        always_ff @(posedge sys_clk or posedge sys_reset) begin
            if (sys_reset) begin
                nf <= 1'b0;
            end else if (pub[i]) begin
                nf <= 1'b1;
            end else if (rd_status) begin
                nf <= 1'b0;
            end
        end

`ifdef ADC_OVERRUN_DETECT_EN
        logic ov;

        always_ff @(posedge sys_clk or posedge sys_reset) begin
            if (sys_reset) begin
                ov <= 1'b0;
            end else if (pub[i] && nf) begin
                ov <= 1'b1;
            end else if (rd_status) begin
                ov <= 1'b0;
            end
        end

        assign ovr_flag[i] = ov;
`else
        assign ovr_flag[i] = 1'b0;
`endif

        assign live[i]     = res;
        assign shad[i]     = shd;
        assign new_flag[i] = nf;
    end

    assign status = 32'(new_flag) | (32'(ovr_flag) << 16);

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            freeze <= 1'b0;
        end else if (ctrl_wr) begin
            freeze <= writedata[0];
        end
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            sample_cnt <= '0;
        end else if (accept) begin
            sample_cnt <= sample_cnt + 32'd1;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            A_STATUS: rd_mux = status;
            A_CTRL:   rd_mux = {31'd0, freeze};
            A_CNT:    rd_mux = sample_cnt;
            default: begin
                for (int i = 0; i < N_CH; i++) begin
                    if (addr == 5'(i)) begin
                        rd_mux = 32'(freeze ? shad[i] : live[i]);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            readdata <= '0;
        end else if (rd_stb) begin
            readdata <= rd_mux;
        end
    end

endmodule
